snn_layer_controller: RTL and testbench
=======================================

Name: snn_layer_controller

Overview:
Parametrised sequencer for one spiking-neuron layer. It accepts input spike events through a valid/ready handshake into a small event FIFO. For each event it walks every neuron's weight row in SRAM, then pulses accumulate. Once per timestep it runs a bounded fire/cleanup loop until the layer's spike vector clears.

Parameters:
N_INPUTS, 16, number of input (presynaptic) lines; power of two, >=2
N_NEURONS, 16, neurons in layer; power of two, >=2
TIMESTEP_CYCLES, 64, clock cycles per timestep; >=4
FIFO_DEPTH, 4, event FIFO entries; power of two, >=2
MAX_FIRE_ITERS, 4, maximum SPIKE passes per timestep; >=1

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
event_valid  in  1  input event present
event_ready  out  1  FIFO can accept; high when FIFO not full
event_addr  in  IN_W=$clog2(N_INPUTS)  source line of event
spike  in  N_NEURONS  current fire vector from neuron array
weight_en  out  1  weight SRAM read enable
weight_addr  out  IN_W+NRN_W  {event row, neuron_cnt}; NRN_W=$clog2(N_NEURONS)
accum_en  out  1  one-cycle accumulate strobe after a full row
spike_done  out  1  one-cycle strobe per SPIKE pass
timestep_tick  out  1  one-cycle strobe when the timestep counter expires
busy  out  1  state != IDLE or FIFO non-empty
fifo_overflow  out  1  sticky; set on event_valid while FIFO full; cleared only by reset

Behaviour:
- Reset:
  - state=IDLE; neuron_cnt=0; ts_cnt=0; fire_iter=0; FIFO empty.
  - All strobes 0; fifo_overflow=0; event_ready=1 in the first cycle after reset.
- Handshake: push on event_valid&&event_ready; write data lands in FIFO next cycle. Push and pop in the same cycle are both permitted when full or empty as long as the FIFO stays consistent; pop with push at count==FIFO_DEPTH is legal.
- ts_cnt:
  - Increments each cycle, saturates at TIMESTEP_CYCLES-1.
  - timestep_tick=1 in the first cycle the saturated value is reached; it does not re-pulse while saturated.
  - Cleared to 0 on entering SPIKE from IDLE.
- States: IDLE, LOAD, ACCUM, SPIKE, CLEANUP.
- IDLE:
  - If ts_cnt saturated -> SPIKE (fire_iter=0). Timestep beats pending events.
  - Else if FIFO non-empty -> pop head into row register, -> LOAD.
- LOAD:
  - weight_en=1; weight_addr={row, neuron_cnt}; neuron_cnt increments each cycle.
  - At neuron_cnt==N_NEURONS-1: neuron_cnt wraps to 0 -> ACCUM.
  - Duration is exactly N_NEURONS cycles.
- ACCUM: accum_en=1 for one cycle -> IDLE.
- SPIKE: spike_done=1 for one cycle, fire_iter++ -> CLEANUP.
- CLEANUP:
  - If spike!=0 and fire_iter<MAX_FIRE_ITERS -> SPIKE.
  - Else -> IDLE, fire_iter=0.
- Events keep being accepted during LOAD/SPIKE/CLEANUP while the FIFO has room.
- A timestep expiring mid-LOAD does not abort the row; SPIKE follows once IDLE is reached.
- weight_addr holds {row,0} when not in LOAD. Outputs are registered state decode; no combinational path from event_valid to any output except event_ready.
- Reset mid-LOAD: everything returns to reset values; the in-flight row and FIFO contents are discarded.

Optional Feature:
SNN_CTRL_LEAK_EN
- Defined:
  - Adds output leak_en (1 bit) and state LEAK.
  - CLEANUP's exit to IDLE goes via LEAK instead, which drives leak_en=1 for exactly one cycle.
  - The neuron array applies membrane decay once per timestep.
- Undefined: no port, no state; CLEANUP exits directly to IDLE.

Decomposition:
- Package snn_ctrl_pkg: state enum type ctrl_state_t, and helper constants for NRN_W/IN_W derivation via $clog2.
- Sub-module snn_event_fifo: parametrised width/depth; synchronous FIFO with full, empty, push, pop, and sticky overflow output.

Test Plan:
1. Reset then single event addr=5 (defaults) -> weight_en high 16 cycles, weight_addr 0x50..0x5F, then accum_en one cycle, busy low after.
2. 6 back-to-back events with FIFO_DEPTH=4 during a LOAD -> event_ready drops after 4th accepted, fifo_overflow sets if valid held, all accepted events processed in order.
3. No events, 64 cycles -> timestep_tick once, SPIKE with spike_done one cycle, spike=0 -> IDLE; ts_cnt restarts, next tick 64 cycles later.
4. spike held 16'h0001 through cleanup -> exactly MAX_FIRE_ITERS=4 spike_done pulses, then IDLE.
5. Event queued at the same cycle ts_cnt saturates -> SPIKE/CLEANUP first, then LOAD of that event.
6. Assert reset at neuron_cnt=7 in LOAD -> next cycle weight_en=0, all outputs at reset values, FIFO empty. With SNN_CTRL_LEAK_EN, scenario 3 additionally shows leak_en for one cycle after CLEANUP.

Source files
------------

// File: rtl/snn_ctrl_pkg.sv
// Shared state type and width helpers for the SNN layer controller.
// The LEAK state exists only when SNN_CTRL_LEAK_EN is defined.
package snn_ctrl_pkg;

    localparam int DEF_N_INPUTS        = 16;
    localparam int DEF_N_NEURONS       = 16;
    localparam int DEF_TIMESTEP_CYCLES = 64;
    localparam int DEF_FIFO_DEPTH      = 4;
    localparam int DEF_MAX_FIRE_ITERS  = 4;

`ifdef SNN_CTRL_LEAK_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_SPIKE   = 3'd3,
        ST_CLEANUP = 3'd4,
        ST_LEAK    = 3'd5
    } ctrl_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_SPIKE   = 3'd3,
        ST_CLEANUP = 3'd4
    } ctrl_state_t;
`endif

    // Bits needed to index n items (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/snn_event_fifo.sv
// Synchronous event FIFO with full/empty flags and a sticky overflow flag that
// records any push request made while full (the request itself is dropped).
module snn_event_fifo
    import snn_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int PTR_W = idx_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == CNT_FULL);
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign rdata_o    = mem_q[rd_ptr_q];
    assign overflow_o = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_i & full_o);
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/snn_layer_controller.sv
// Sequencer for one spiking-neuron layer: queued events drive weight-row walks and
// accumulate strobes; each timestep runs a bounded fire/cleanup loop. Option: SNN_CTRL_LEAK_EN.
module snn_layer_controller
    import snn_ctrl_pkg::*;
#(
    parameter int N_INPUTS        = DEF_N_INPUTS,
    parameter int N_NEURONS       = DEF_N_NEURONS,
    parameter int TIMESTEP_CYCLES = DEF_TIMESTEP_CYCLES,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int MAX_FIRE_ITERS  = DEF_MAX_FIRE_ITERS
) (
    input  logic                                          clock,
    input  logic                                          reset,
    // An event transfers on a rising clock edge where event_valid && event_ready;
    // event_ready depends only on FIFO occupancy, never on event_valid.
    input  logic                                          event_valid,
    output logic                                          event_ready,
    input  logic [$clog2(N_INPUTS)-1:0]                   event_addr,
    input  logic [N_NEURONS-1:0]                          spike,
    output logic                                          weight_en,
    output logic [$clog2(N_INPUTS)+$clog2(N_NEURONS)-1:0] weight_addr,
    output logic                                          accum_en,
    output logic                                          spike_done,
    output logic                                          timestep_tick,
    output logic                                          busy,
    output logic                                          fifo_overflow,
`ifdef SNN_CTRL_LEAK_EN
    output logic                                          leak_en,
`endif
    output ctrl_state_t                                   dbg_state
);

    localparam int IN_W  = idx_width(N_INPUTS);
    localparam int NRN_W = idx_width(N_NEURONS);
    localparam int TS_W  = idx_width(TIMESTEP_CYCLES);
    localparam int FI_W  = cnt_width(MAX_FIRE_ITERS);

    localparam logic [NRN_W-1:0] NRN_LAST = NRN_W'(N_NEURONS - 1);
    localparam logic [NRN_W-1:0] NRN_ZERO = '0;
    localparam logic [TS_W-1:0]  TS_LAST  = TS_W'(TIMESTEP_CYCLES - 1);
    localparam logic [FI_W-1:0]  FI_MAX   = FI_W'(MAX_FIRE_ITERS);

    ctrl_state_t           state_q;
    logic [NRN_W-1:0]      neuron_cnt_q;
    logic [NRN_W-1:0]      cnt_inc;
    logic [FI_W-1:0]       fire_iter_q;
    logic [IN_W-1:0]       row_q;
    logic [TS_W-1:0]       ts_cnt_q, ts_cnt_d;
    logic                  tick_q, tick_d;
    logic                  weight_en_q;
    logic [IN_W+NRN_W-1:0] weight_addr_q;
    logic                  accum_en_q;
    logic                  spike_done_q;
`ifdef SNN_CTRL_LEAK_EN
    logic                  leak_en_q;
`endif

    logic                  ts_sat;
    logic                  enter_spike;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [IN_W-1:0]       fifo_head;

    snn_event_fifo #(
        .WIDTH (IN_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clock),
        .rst_i      (reset),
        .push_i     (event_valid),
        .pop_i      (fifo_pop),
        .wdata_i    (event_addr),
        .rdata_o    (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_overflow)
    );

    // A saturated timestep takes priority over queued events in IDLE.
    assign ts_sat      = (ts_cnt_q == TS_LAST);
    assign enter_spike = (state_q == ST_IDLE) && ts_sat;
    assign fifo_pop    = (state_q == ST_IDLE) && !ts_sat && !fifo_empty;
    assign cnt_inc     = neuron_cnt_q + 1'b1;

    always_comb begin
        ts_cnt_d = ts_cnt_q;
        if (enter_spike) begin
            ts_cnt_d = '0;
        end else if (!ts_sat) begin
            ts_cnt_d = ts_cnt_q + 1'b1;
        end
        tick_d = !ts_sat && (ts_cnt_d == TS_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            ts_cnt_q <= ts_cnt_d;
            tick_q   <= tick_d;
        end
    end

    // Strobe registers are loaded together with the state they belong to,
    // so each output is high exactly while the FSM sits in its state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            neuron_cnt_q  <= '0;
            fire_iter_q   <= '0;
            row_q         <= '0;
            weight_en_q   <= 1'b0;
            weight_addr_q <= '0;
            accum_en_q    <= 1'b0;
            spike_done_q  <= 1'b0;
`ifdef SNN_CTRL_LEAK_EN
            leak_en_q     <= 1'b0;
`endif
        end else begin
            weight_en_q  <= 1'b0;
            accum_en_q   <= 1'b0;
            spike_done_q <= 1'b0;
`ifdef SNN_CTRL_LEAK_EN
            leak_en_q    <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (ts_sat) begin
                        state_q      <= ST_SPIKE;
                        fire_iter_q  <= '0;
                        spike_done_q <= 1'b1;
                    end else if (!fifo_empty) begin
                        state_q       <= ST_LOAD;
                        row_q         <= fifo_head;
                        weight_en_q   <= 1'b1;
                        weight_addr_q <= {fifo_head, NRN_ZERO};
                    end
                end
                ST_LOAD: begin
                    if (neuron_cnt_q == NRN_LAST) begin
                        state_q       <= ST_ACCUM;
                        neuron_cnt_q  <= '0;
                        weight_addr_q <= {row_q, NRN_ZERO};
                        accum_en_q    <= 1'b1;
                    end else begin
                        neuron_cnt_q  <= cnt_inc;
                        weight_en_q   <= 1'b1;
                        weight_addr_q <= {row_q, cnt_inc};
                    end
                end
                ST_ACCUM: begin
                    state_q <= ST_IDLE;
                end
                ST_SPIKE: begin
                    state_q     <= ST_CLEANUP;
                    fire_iter_q <= fire_iter_q + 1'b1;
                end
                ST_CLEANUP: begin
                    if ((spike != '0) && (fire_iter_q < FI_MAX)) begin
                        state_q      <= ST_SPIKE;
                        spike_done_q <= 1'b1;
                    end else begin
                        fire_iter_q <= '0;
`ifdef SNN_CTRL_LEAK_EN
                        state_q     <= ST_LEAK;
                        leak_en_q   <= 1'b1;
`else
                        state_q     <= ST_IDLE;
`endif
                    end
                end
`ifdef SNN_CTRL_LEAK_EN
                ST_LEAK: begin
                    state_q <= ST_IDLE;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign event_ready   = !fifo_full;
    assign weight_en     = weight_en_q;
    assign weight_addr   = weight_addr_q;
    assign accum_en      = accum_en_q;
    assign spike_done    = spike_done_q;
    assign timestep_tick = tick_q;
    assign busy          = (state_q != ST_IDLE) || !fifo_empty;
    assign dbg_state     = state_q;
`ifdef SNN_CTRL_LEAK_EN
    assign leak_en       = leak_en_q;
`endif

endmodule

// File: tb/tb_snn_layer_controller.sv
// Directed bench for snn_layer_controller: table-driven single-event rows plus
// hand-written FIFO-fill, timestep, fire-loop, priority and mid-LOAD reset sequences.
`timescale 1ns/1ps
module tb_snn_layer_controller;
    import snn_ctrl_pkg::*;

    localparam int N_INPUTS        = 16;
    localparam int N_NEURONS       = 16;
    localparam int TIMESTEP_CYCLES = 64;
    localparam int FIFO_DEPTH      = 4;
    localparam int MAX_FIRE_ITERS  = 4;
`ifdef SNN_CTRL_LEAK_EN
    localparam int LK = 1;
`else
    localparam int LK = 0;
`endif

    typedef struct {
        logic [3:0] addr;
        logic [7:0] first_addr;
        int         load_start;
        int         accum_cyc;
    } vec_t;

    logic        clock       = 1'b0;
    logic        reset       = 1'b1;
    logic        event_valid = 1'b0;
    logic [3:0]  event_addr  = '0;
    logic [15:0] spike       = '0;
    logic        event_ready;
    logic        weight_en;
    logic [7:0]  weight_addr;
    logic        accum_en;
    logic        spike_done;
    logic        timestep_tick;
    logic        busy;
    logic        fifo_overflow;
`ifdef SNN_CTRL_LEAK_EN
    logic        leak_en;
`endif
    ctrl_state_t dbg_state;

    int         errors  = 0;
    int         checks  = 0;
    int         cyc     = 0;
    int         run_len = 0;
    logic       we_prev = 1'b0;
    logic [3:0] exp_q[$];
    vec_t       vecs[4];
    logic [3:0] t2_ev[6];

    snn_layer_controller #(
        .N_INPUTS        (N_INPUTS),
        .N_NEURONS       (N_NEURONS),
        .TIMESTEP_CYCLES (TIMESTEP_CYCLES),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .MAX_FIRE_ITERS  (MAX_FIRE_ITERS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_addr    (event_addr),
        .spike         (spike),
        .weight_en     (weight_en),
        .weight_addr   (weight_addr),
        .accum_en      (accum_en),
        .spike_done    (spike_done),
        .timestep_tick (timestep_tick),
        .busy          (busy),
        .fifo_overflow (fifo_overflow),
`ifdef SNN_CTRL_LEAK_EN
        .leak_en       (leak_en),
`endif
        .dbg_state     (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Advance one cycle, sample at the falling edge, and score any weight-row walk.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
        cyc++;
        if (!reset) begin
            if (weight_en && !we_prev) begin
                run_len = 0;
                check("load_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("row_order", weight_addr[7:4], exp_q.pop_front());
            end
            if (weight_en) begin
                check("addr_low", weight_addr[3:0], run_len);
                run_len++;
            end
            if (!weight_en && we_prev) begin
                check("load_len", run_len, 16);
                check("accum_after_load", accum_en, 1);
            end
        end
        we_prev = weight_en;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset       = 1'b1;
        event_valid = 1'b0;
        spike       = '0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset   = 1'b0;
        cyc     = 0;
        we_prev = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic in_load;
        int   exp_addr;
        int   accepted;
        int   idx;
        logic rdy;
        int   sd_count;
        int   first_sd;
        logic done;

        vecs[0] = '{4'd5,  8'h50, 2, 18};
        vecs[1] = '{4'd0,  8'h00, 2, 18};
        vecs[2] = '{4'd15, 8'hF0, 2, 18};
        vecs[3] = '{4'd10, 8'hA0, 2, 18};
        t2_ev   = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};

        // Single event per row address: 16-cycle walk, accumulate, idle.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            if (v == 0) begin
                check("rst_weight_en", weight_en, 0);
                check("rst_weight_addr", weight_addr, 0);
                check("rst_accum_en", accum_en, 0);
                check("rst_spike_done", spike_done, 0);
                check("rst_tick", timestep_tick, 0);
                check("rst_busy", busy, 0);
                check("rst_ready", event_ready, 1);
                check("rst_overflow", fifo_overflow, 0);
                check("rst_state", dbg_state, ST_IDLE);
`ifdef SNN_CTRL_LEAK_EN
                check("rst_leak_en", leak_en, 0);
`endif
            end
            exp_q.push_back(vecs[v].addr);
            event_addr  = vecs[v].addr;
            event_valid = 1'b1;
            for (int k = 1; k <= 20; k++) begin
                step();
                if (k == 1) event_valid = 1'b0;
                in_load = (k >= vecs[v].load_start) && (k < vecs[v].load_start + 16);
                check("t1_weight_en", weight_en, in_load);
                check("t1_accum_en", accum_en, k == vecs[v].accum_cyc);
                check("t1_busy", busy, k <= vecs[v].accum_cyc);
                if (in_load) exp_addr = vecs[v].first_addr + (k - vecs[v].load_start);
                else if (k >= vecs[v].load_start) exp_addr = vecs[v].first_addr;
                else exp_addr = 0;
                check("t1_weight_addr", weight_addr, exp_addr);
            end
            check("t1_drained", exp_q.size(), 0);
        end

        // Fill the FIFO during a LOAD, hold valid while full, then drain in order.
        do_reset();
        exp_q.push_back(4'd1);
        for (int i = 0; i < 4; i++) exp_q.push_back(t2_ev[i]);
        event_addr  = 4'd1;
        event_valid = 1'b1;
        step();
        event_valid = 1'b0;
        step();
        step();
        accepted    = 0;
        idx         = 0;
        event_addr  = t2_ev[0];
        event_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rdy = event_ready;
            step();
            if (rdy) begin
                accepted++;
                idx++;
                if (idx < 6) event_addr = t2_ev[idx];
            end
        end
        check("t2_accept_count", accepted, 4);
        check("t2_ready_full", event_ready, 0);
        check("t2_overflow", fifo_overflow, 1);
        event_valid = 1'b0;
        sd_count = 0;
        first_sd = -1;
        done     = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            step();
            if (spike_done) begin
                sd_count++;
                if (first_sd < 0) first_sd = cyc;
            end
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        check("t2_drain_done", done, 1);
        check("t2_spike_passes", sd_count, 1);
        check("t2_spike_cyc", first_sd, 74);
        check("t2_overflow_sticky", fifo_overflow, 1);

        // Idle timesteps: tick, one spike pass, counter restart.
        do_reset();
        check("t3_overflow_cleared", fifo_overflow, 0);
        for (int k = 1; k <= 130; k++) begin
            step();
            check("t3_tick", timestep_tick, (k == 63) || (k == 127));
            check("t3_spike_done", spike_done, (k == 64) || (k == 128));
            check("t3_busy", busy, ((k >= 64) && (k <= 65 + LK)) || ((k >= 128) && (k <= 129 + LK)));
`ifdef SNN_CTRL_LEAK_EN
            check("t3_leak_en", leak_en, (k == 66) || (k == 130));
`endif
        end

        // Spike vector never clears: fire loop bounded by MAX_FIRE_ITERS.
        do_reset();
        spike = 16'h0001;
        for (int k = 1; k <= 90; k++) begin
            step();
            check("t4_spike_done", spike_done, (k == 64) || (k == 66) || (k == 68) || (k == 70));
            check("t4_busy", busy, (k >= 64) && (k <= 71 + LK));
`ifdef SNN_CTRL_LEAK_EN
            check("t4_leak_en", leak_en, k == 72);
`endif
        end
        spike = '0;

        // Event lands as the timestep saturates: spike pass first, then the row.
        do_reset();
        for (int k = 1; k <= 62; k++) step();
        exp_q.push_back(4'd9);
        event_addr  = 4'd9;
        event_valid = 1'b1;
        step();
        event_valid = 1'b0;
        check("t5_tick", timestep_tick, 1);
        check("t5_busy", busy, 1);
        check("t5_state", dbg_state, ST_IDLE);
        for (int k = 64; k <= 85 + LK; k++) begin
            step();
            check("t5_spike_done", spike_done, k == 64);
            check("t5_weight_en", weight_en, (k >= 67 + LK) && (k <= 82 + LK));
            if (k == 67 + LK) check("t5_first_addr", weight_addr, 8'h90);
        end
        check("t5_drained", exp_q.size(), 0);

        // Reset at neuron_cnt=7 discards the row and the queued event.
        do_reset();
        exp_q.push_back(4'd3);
        event_addr  = 4'd3;
        event_valid = 1'b1;
        step();
        event_addr = 4'd4;
        step();
        event_valid = 1'b0;
        for (int k = 3; k <= 9; k++) step();
        check("t6_mid_addr", weight_addr, 8'h37);
        check("t6_mid_state", dbg_state, ST_LOAD);
        reset = 1'b1;
        step();
        check("t6_weight_en", weight_en, 0);
        check("t6_weight_addr", weight_addr, 0);
        check("t6_accum_en", accum_en, 0);
        check("t6_busy", busy, 0);
        check("t6_ready", event_ready, 1);
        check("t6_state", dbg_state, ST_IDLE);
        reset = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            check("t6_no_stale_load", weight_en, 0);
            check("t6_idle", busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: run did not complete (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
